// File: rtl/commit_trace_fifo.sv
// Commit-stream trace FIFO: buffers retiring register writes, tags each with a sequence
// number and counts drops on overflow. Optional macro: COMMIT_X0_FILTER_EN (ignore rd==0).
module commit_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SEQ_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_data,
  input  logic                     flush,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [4:0]               trace_rd,
  output logic [31:0]              trace_data,
  output logic [SEQ_W-1:0]         trace_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic [31:0]      pc_mem   [DEPTH];
  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [SEQ_W-1:0] seq_mem  [DEPTH];

  logic eligible, full, pop_req, pop, push, drop;

`ifdef COMMIT_X0_FILTER_EN
  assign eligible = commit_valid && (commit_rd != 5'd0);
`else
  assign eligible = commit_valid;
`endif

  assign full    = (count_q == CW'(DEPTH));
  assign pop_req = trace_valid && trace_ready;
  // A flush overrides both pop and push; the flushed commit still consumes a tag.
  assign pop     = pop_req && !flush;
  assign push    = eligible && !flush && (!full || pop_req);
  assign drop    = eligible && !flush && full && !pop_req;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (eligible) begin
      seq_d = seq_q + SEQ_W'(1);
    end
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= commit_pc;
      rd_mem[wr_ptr_q]   <= commit_rd;
      data_mem[wr_ptr_q] <= commit_data;
      seq_mem[wr_ptr_q]  <= seq_q;
    end
  end

  assign trace_valid = (count_q != '0);
  assign trace_pc    = pc_mem[rd_ptr_q];
  assign trace_rd    = rd_mem[rd_ptr_q];
  assign trace_data  = data_mem[rd_ptr_q];
  assign trace_seq   = seq_mem[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_cnt_q;

endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Buffers the per-cycle writeback commit stream (valid, PC, rd, data) from the pipelined core's debug wrapper and hands it out through a valid/ready interface to a slower consumer: UVM monitor, scoreboard or trace dump. Each accepted commit is tagged with a free-running sequence number, so a consumer can detect gaps. Drops on overflow are counted and flagged rather than stalling the core, because the core has no backpressure path.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, at least 2
- SEQ_W, 32, width of the sequence tag

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- commit_valid  in  1  a register write retires this cycle
- commit_pc  in  32  PC of the retiring instruction
- commit_rd  in  5  destination register
- commit_data  in  32  value written
- flush  in  1  synchronous clear of buffered entries
- trace_valid  out  1  head entry available
- trace_ready  in  1  consumer takes the head entry this cycle
- trace_pc  out  32  head entry PC
- trace_rd  out  5  head entry rd
- trace_data  out  32  head entry data
- trace_seq  out  SEQ_W  head entry sequence tag
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one commit has been dropped
- drop_count  out  16  commits dropped because the FIFO was full; saturates at 0xFFFF

## Operation
- Storage is a circular buffer with write pointer, read pointer and occupancy counter.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Eligible commit: commit_valid=1, subject to the Configuration filter.
- Sequence counter seq_next:
  - Increments by 1, modulo 2^SEQ_W, for every eligible commit, whether it is enqueued, dropped or flushed.
  - Enqueued entries carry the pre-increment value.
- Push: an eligible commit with flush=0 is written at the write pointer when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- Drop: an eligible commit with flush=0, count==DEPTH and no pop.
  - The entry is not written.
  - overflow is set.
  - drop_count increments unless it is already 0xFFFF.
- Pop: trace_valid && trace_ready advances the read pointer.
- Push and pop in the same cycle: count is unchanged.
- Outputs:
  - trace_valid = (count != 0).
  - trace_pc, trace_rd, trace_data and trace_seq are read combinationally at the read pointer.
  - When trace_valid=0 the head fields are don't-care; the bench must not check them.
- Flush=1:
  - Next cycle: count=0, with read and write pointers equal.
  - A pop in the same cycle is irrelevant.
  - An eligible commit in the same cycle is discarded: seq_next still increments; drop_count and overflow are unchanged.
  - seq_next, overflow and drop_count are not cleared by flush.
- Reset clears the pointers, count, seq_next, overflow and drop_count. Storage contents are not reset.

## Timing
- Reset values: trace_valid=0, count=0, overflow=0, drop_count=0, trace_seq value is don't-care, next tag issued is 0.
- Latency: a commit accepted at edge N is visible on trace_* in the cycle after edge N, provided the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Handshake: once trace_valid=1, the head fields stay stable until popped or flushed. The consumer may hold trace_ready=1 continuously.
- Reset is honoured in the middle of any operation; all in-flight entries are lost.
- Full FIFO with simultaneous push and pop is the only case where a full FIFO accepts a push.

## Configuration
- COMMIT_X0_FILTER_EN:
  - Defined: a commit with commit_rd==0 is not eligible. It is not enqueued, not counted as a drop, and does not increment seq_next.
  - Undefined: commits with rd==0 are treated like any other commit.

## Test plan
- Basic latency:
  - Stimulus: after reset, one commit (pc=0x10, rd=4, data=7) with trace_ready=1.
  - Response: trace_valid=1 for exactly one cycle, showing 0x10/4/7 with seq=0; count then returns to 0.
- Full FIFO, drop:
  - Stimulus: trace_ready=0, then 18 consecutive commits with DEPTH=16.
  - Response: count=16, drop_count=2, overflow=1.
  - Draining yields seq 0..15 in order; the next accepted commit carries seq=18.
- Full FIFO, push with pop:
  - Stimulus: fill to 16, then assert commit_valid and trace_ready together in one cycle.
  - Response: no drop, count stays 16, the head advances to seq=1.
- Flush with commit:
  - Stimulus: 5 entries buffered, then flush=1 with a commit in the same cycle.
  - Response: count=0 and trace_valid=0 next cycle; drop_count unchanged; the next commit carries seq=6.
- Pointer wrap:
  - Stimulus: 40 commits under a random trace_ready pattern that never fills the FIFO.
  - Response: every commit is observed exactly once, in order, with contiguous seq values.
- Filter macro:
  - Stimulus: commits with rd=0 and rd=3.
  - Defined: only the rd=3 commit is output, with seq=0.
  - Undefined: both are output, with seq=0 and seq=1.
